// File: rtl/globalDefinitions.sv
// -----------------------------------------------------------------------------
// globalDefinitions
// Project-wide fixed-point widths shared by the scaler blocks.
//   fixed     : number of fractional bits in a fixed-point value, and also the
//               width of integer coordinates and image sizes.
//   fixedbits : full width of a fixed-point value (integer + fraction).
// A value of 1.0 is (1 << fixed).
// -----------------------------------------------------------------------------
package globalDefinitions;

    localparam int fixed     = 18;
    localparam int fixedbits = 32;

endpackage

// File: rtl/scale_coordinate_generation_pkg.sv
// -----------------------------------------------------------------------------
// pkg_scaleCoordinateGeneration
// Shared types for the scale coordinate generator.
//   STATES_t             : frame sequencer states.
//   DEFAULT_DRAIN_CYCLES : cycles from the last accepted start until the pixel
//                          generator's final scale-cache write is visible.
// -----------------------------------------------------------------------------
package pkg_scaleCoordinateGeneration;

    typedef enum logic [2:0] {
        S_Idle,
        S_Issue,
        S_Advance,
        S_Drain,
        S_Done
    } STATES_t;

    localparam int DEFAULT_DRAIN_CYCLES = 12;

endpackage

// File: rtl/structs.sv
// -----------------------------------------------------------------------------
// structs
// Handshake bundles between the scaler sequencers and the scale pixel
// generator.
//   struct_scalePixelGeneration_in  : start pulse plus the source integer
//                                     address (sx, sy), the fixed-point
//                                     fractional weights (fx, fy) and the
//                                     destination raster position (dx, dy).
//   struct_scalePixelGeneration_out : ready, high when the generator can accept
//                                     a new pixel.
// -----------------------------------------------------------------------------
package structs;

    import globalDefinitions::*;

    typedef struct packed {
        logic                 start;
        logic [fixed-1:0]     sx;
        logic [fixed-1:0]     sy;
        logic [fixedbits-1:0] fx;
        logic [fixedbits-1:0] fy;
        logic [fixed-1:0]     dx;
        logic [fixed-1:0]     dy;
    } struct_scalePixelGeneration_in;

    typedef struct packed {
        logic ready;
    } struct_scalePixelGeneration_out;

endpackage

// File: rtl/scale_coordinate_generation_split.sv
// -----------------------------------------------------------------------------
// scaleCoordSplit
// Purely combinational split of an unsigned fixed-point accumulator into an
// integer source coordinate and a fractional interpolation weight.
//
// Build option: SCALE_COORD_CLAMP_EN
//   defined   : when the integer part is >= src_size-1 the output is pinned to
//               int_part = src_size-2 and frac_part = 1.0, so the generator's
//               +1 neighbour read stays inside the image.
//   undefined : raw split, the caller keeps the accumulator in range.
//
// Ports:
//   acc       in  [fixedbits-1:0] accumulated source position
//   src_size  in  [fixed-1:0]     source extent along this axis (>= 2)
//   int_part  out [fixed-1:0]     integer coordinate (truncated to fixed bits)
//   frac_part out [fixedbits-1:0] fraction, zero-extended
// -----------------------------------------------------------------------------
module scaleCoordSplit
    import globalDefinitions::*;
(
    input  logic [fixedbits-1:0] acc,
    input  logic [fixed-1:0]     src_size,
    output logic [fixed-1:0]     int_part,
    output logic [fixedbits-1:0] frac_part
);

    logic [fixedbits-1:0] whole;
    logic [fixed-1:0]     raw_int;
    logic [fixedbits-1:0] raw_frac;

    assign whole    = acc >> fixed;
    assign raw_int  = fixed'(whole);
    assign raw_frac = fixedbits'(acc[fixed-1:0]);

`ifdef SCALE_COORD_CLAMP_EN

    localparam logic [fixedbits-1:0] ONE = fixedbits'(1) << fixed;

    logic [fixedbits-1:0] last_index;

    // The comparison is done at full accumulator width so a wrapped or very
    // large integer part cannot alias below the limit after truncation.
    assign last_index = fixedbits'(src_size) - fixedbits'(1);

    always_comb begin
        int_part  = raw_int;
        frac_part = raw_frac;
        if (whole >= last_index) begin
            int_part  = src_size - fixed'(2);
            frac_part = ONE;
        end
    end

`else

    logic unused_src_size;

    // Without clamping the source size plays no role in the split.
    assign unused_src_size = ^src_size;

    always_comb begin
        int_part  = raw_int;
        frac_part = raw_frac;
    end

`endif

endmodule

// File: rtl/scale_coordinate_generation.sv
// -----------------------------------------------------------------------------
// scale_coordinate_generation
// Frame sequencer in front of the scale pixel generator. Walks the destination
// image in raster order, accumulates the fixed-point source position, splits it
// into integer address + fractional weight and issues one start per pixel under
// the generator's ready/start handshake. After the last pixel it waits for the
// generator's write pipeline to drain and then pulses done.
//
// Build option: SCALE_COORD_CLAMP_EN (see scaleCoordSplit) clamps the source
// coordinates so the +1 neighbour stays inside the image.
//
// Parameters:
//   DRAIN_CYCLES  cycles from the last accepted start until the final
//                 scale-cache write of the generator is visible
// Ports:
//   clk                      in  clock
//   reset                    in  asynchronous active-high reset
//   cfg_start                in  frame start pulse, honoured only when idle
//   cfg_src_w / cfg_src_h    in  source size (>= 2)
//   cfg_dst_w / cfg_dst_h    in  destination size (0 gives an empty frame)
//   cfg_step_x / cfg_step_y  in  source advance per destination pixel
//   spg_out                  in  generator status (ready)
//   spg_in                   out generator request (start, sx, sy, fx, fy, dx, dy)
//   busy                     out high from frame acceptance through done
//   done                     out one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module scale_coordinate_generation
    import globalDefinitions::*, structs::*, pkg_scaleCoordinateGeneration::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
)
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_start,
    input  logic [fixed-1:0]               cfg_src_w,
    input  logic [fixed-1:0]               cfg_src_h,
    input  logic [fixed-1:0]               cfg_dst_w,
    input  logic [fixed-1:0]               cfg_dst_h,
    input  logic [fixedbits-1:0]           cfg_step_x,
    input  logic [fixedbits-1:0]           cfg_step_y,
    input  struct_scalePixelGeneration_out spg_out,
    output struct_scalePixelGeneration_in  spg_in,
    output logic                           busy,
    output logic                           done
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    STATES_t state;
    STATES_t state_next;

    logic [fixed-1:0]     src_w;
    logic [fixed-1:0]     src_h;
    logic [fixed-1:0]     dst_w;
    logic [fixed-1:0]     dst_h;
    logic [fixedbits-1:0] step_x;
    logic [fixedbits-1:0] step_y;

    logic [fixed-1:0]     dx;
    logic [fixed-1:0]     dy;
    logic [fixedbits-1:0] x_acc;
    logic [fixedbits-1:0] y_acc;
    logic [DRAIN_W-1:0]   drain_cnt;

    logic [fixed-1:0]     sx;
    logic [fixed-1:0]     sy;
    logic [fixedbits-1:0] fx;
    logic [fixedbits-1:0] fy;

    logic last_x;
    logic last_y;
    logic last_pixel;
    logic start;

    assign last_x     = (dx == dst_w - fixed'(1));
    assign last_y     = (dy == dst_h - fixed'(1));
    assign last_pixel = last_x && last_y;

    // One splitter per axis turns the accumulator into address + weight.
    scaleCoordSplit u_split_x (
        .acc       (x_acc),
        .src_size  (src_w),
        .int_part  (sx),
        .frac_part (fx)
    );

    scaleCoordSplit u_split_y (
        .acc       (y_acc),
        .src_size  (src_h),
        .int_part  (sy),
        .frac_part (fy)
    );

    // State register. Reset drops everything at once, so a frame interrupted
    // by reset never produces another start or a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_Idle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Start is only ever offered while issuing and is gated
    // by ready, so a stalled generator just holds the sequencer in S_Issue.
    // A zero destination dimension skips straight to the done pulse.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            S_Idle: begin
                if (cfg_start) begin
                    if (cfg_dst_w == '0 || cfg_dst_h == '0) begin
                        state_next = S_Done;
                    end else begin
                        state_next = S_Issue;
                    end
                end
            end
            S_Issue: begin
                start = spg_out.ready;
                if (spg_out.ready) begin
                    state_next = last_pixel ? S_Drain : S_Advance;
                end
            end
            S_Advance: begin
                state_next = S_Issue;
            end
            S_Drain: begin
                if (drain_cnt == '0) begin
                    state_next = S_Done;
                end
            end
            S_Done: begin
                state_next = S_Idle;
            end
            default: begin
                state_next = S_Idle;
            end
        endcase
    end

    // Frame datapath: configuration is captured only on an accepted start so
    // mid-frame cfg changes are invisible. The accumulators advance by whole
    // steps and wrap silently; the x accumulator restarts at every new row.
    // The drain counter is armed on the edge that accepts the last pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_w     <= '0;
            src_h     <= '0;
            dst_w     <= '0;
            dst_h     <= '0;
            step_x    <= '0;
            step_y    <= '0;
            dx        <= '0;
            dy        <= '0;
            x_acc     <= '0;
            y_acc     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_Idle: begin
                    if (cfg_start) begin
                        src_w  <= cfg_src_w;
                        src_h  <= cfg_src_h;
                        dst_w  <= cfg_dst_w;
                        dst_h  <= cfg_dst_h;
                        step_x <= cfg_step_x;
                        step_y <= cfg_step_y;
                        dx     <= '0;
                        dy     <= '0;
                        x_acc  <= '0;
                        y_acc  <= '0;
                    end
                end
                S_Issue: begin
                    if (spg_out.ready && last_pixel) begin
                        drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
                S_Advance: begin
                    if (last_x) begin
                        dx    <= '0;
                        x_acc <= '0;
                        dy    <= dy + fixed'(1);
                        y_acc <= y_acc + step_y;
                    end else begin
                        dx    <= dx + fixed'(1);
                        x_acc <= x_acc + step_x;
                    end
                end
                S_Drain: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request bundle: everything except start comes straight from registers,
    // so the coordinates are stable for the whole time a pixel is offered.
    always_comb begin
        spg_in       = '0;
        spg_in.start = start;
        spg_in.sx    = sx;
        spg_in.sy    = sy;
        spg_in.fx    = fx;
        spg_in.fy    = fy;
        spg_in.dx    = dx;
        spg_in.dy    = dy;
    end

    assign busy = (state != S_Idle);
    assign done = (state == S_Done);

endmodule

// File: tb/tb_scale_coordinate_generation.sv
// -----------------------------------------------------------------------------
// tb_scale_coordinate_generation
// Self-checking bench for scale_coordinate_generation. The expected pixel list
// of each frame is computed from the scaling rules (position = index * step,
// split by division by 1.0, optional clamp when SCALE_COORD_CLAMP_EN is
// defined) and compared against the starts seen at the generator interface.
// Timing of the first start, done and busy is checked in clock edges.
// -----------------------------------------------------------------------------
module tb_scale_coordinate_generation;

    import globalDefinitions::*;
    import structs::*;

    localparam int DRAIN = 12;
    localparam logic [63:0] ONE_VAL = 64'(1) << fixed;

    typedef struct packed {
        logic [fixed-1:0]     sx;
        logic [fixed-1:0]     sy;
        logic [fixedbits-1:0] fx;
        logic [fixedbits-1:0] fy;
        logic [fixed-1:0]     dx;
        logic [fixed-1:0]     dy;
    } pix_t;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           cfg_start;
    logic [fixed-1:0]               cfg_src_w;
    logic [fixed-1:0]               cfg_src_h;
    logic [fixed-1:0]               cfg_dst_w;
    logic [fixed-1:0]               cfg_dst_h;
    logic [fixedbits-1:0]           cfg_step_x;
    logic [fixedbits-1:0]           cfg_step_y;
    struct_scalePixelGeneration_out spg_out;
    struct_scalePixelGeneration_in  spg_in;
    logic                           busy;
    logic                           done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int rdy_mode     = 0;   // 0: ready high, 1: random ready, 2: ready low
    int bad_start    = 0;

    pix_t obs_q[$];
    int   hs_edges[$];
    int   done_edges[$];

    scale_coordinate_generation #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_src_w  (cfg_src_w),
        .cfg_src_h  (cfg_src_h),
        .cfg_dst_w  (cfg_dst_w),
        .cfg_dst_h  (cfg_dst_h),
        .cfg_step_x (cfg_step_x),
        .cfg_step_y (cfg_step_y),
        .spg_out    (spg_out),
        .spg_in     (spg_in),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Ready driver, updated a little after each rising edge.
    initial begin
        spg_out.ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       spg_out.ready = 1'b1;
                1:       spg_out.ready = 1'($urandom_range(0, 1));
                default: spg_out.ready = 1'b0;
            endcase
        end
    end

    // Interface monitor on the falling edge: records every handshake and every
    // done cycle together with the rising edge that will consume it.
    always @(negedge clk) begin
        if (spg_in.start && !spg_out.ready) bad_start++;
        if (spg_in.start && spg_out.ready) begin
            obs_q.push_back({spg_in.sx, spg_in.sy, spg_in.fx, spg_in.fy, spg_in.dx, spg_in.dy});
            hs_edges.push_back(cyc + 1);
        end
        if (done) done_edges.push_back(cyc + 1);
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic void splitModel(input logic [63:0] acc, input int src,
                                       output logic [fixed-1:0] ip, output logic [fixedbits-1:0] fp);
        logic [63:0] whole;
        whole = acc / ONE_VAL;
        ip    = fixed'(whole);
        fp    = fixedbits'(acc % ONE_VAL);
`ifdef SCALE_COORD_CLAMP_EN
        if (whole >= 64'(src - 1)) begin
            ip = fixed'(src - 2);
            fp = fixedbits'(ONE_VAL);
        end
`endif
    endfunction

    task automatic applyStimulus(input string tag, input int sw, input int sh, input int dw, input int dh,
                                 input logic [31:0] stx, input logic [31:0] sty, input int mode, input int stall);
        pix_t exp_q[$];
        pix_t p;
        pix_t held;
        int   base_obs, base_hs, base_done, base_bad, t0, guard, limit, n_obs, stall_bad;
        logic [63:0] ax, ay;

        for (int y = 0; y < dh; y++) begin
            for (int x = 0; x < dw; x++) begin
                ax = (64'(x) * {32'h0, stx}) & 64'hFFFF_FFFF;
                ay = (64'(y) * {32'h0, sty}) & 64'hFFFF_FFFF;
                splitModel(ax, sw, p.sx, p.fx);
                splitModel(ay, sh, p.sy, p.fy);
                p.dx = fixed'(x);
                p.dy = fixed'(y);
                exp_q.push_back(p);
            end
        end

        base_obs  = obs_q.size();
        base_hs   = hs_edges.size();
        base_done = done_edges.size();
        base_bad  = bad_start;
        rdy_mode  = (stall > 0) ? 2 : mode;

        @(posedge clk); #1;
        cfg_src_w  = fixed'(sw);
        cfg_src_h  = fixed'(sh);
        cfg_dst_w  = fixed'(dw);
        cfg_dst_h  = fixed'(dh);
        cfg_step_x = stx;
        cfg_step_y = sty;
        cfg_start  = 1'b1;
        t0 = cyc;

        // A second pulse with different settings lands while the frame runs.
        @(posedge clk); #1;
        checkOutput({tag, "_busy_on"}, 64'(busy), 64'd1);
        cfg_start  = 1'b1;
        cfg_dst_w  = fixed'($urandom_range(1, 7));
        cfg_dst_h  = fixed'($urandom_range(1, 7));
        cfg_step_x = $urandom();
        cfg_step_y = $urandom();
        @(posedge clk); #1;
        cfg_start = 1'b0;

        if (stall > 0) begin
            held = {spg_in.sx, spg_in.sy, spg_in.fx, spg_in.fy, spg_in.dx, spg_in.dy};
            stall_bad = 0;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (spg_in.start !== 1'b0) stall_bad++;
                if ({spg_in.sx, spg_in.sy, spg_in.fx, spg_in.fy, spg_in.dx, spg_in.dy} !== held) stall_bad++;
            end
            checkOutput({tag, "_stall_quiet"}, 64'(stall_bad), 64'd0);
            checkOutput({tag, "_stall_busy"}, 64'(busy), 64'd1);
            rdy_mode = mode;
        end

        limit = (dw * dh + 1) * 20 + 100;
        guard = 0;
        while (done_edges.size() == base_done && guard < limit) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput({tag, "_done_seen"}, 64'(done_edges.size() > base_done), 64'd1);
        checkOutput({tag, "_busy_off"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done_low"}, 64'(done), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput({tag, "_done_count"}, 64'(done_edges.size() - base_done), 64'd1);

        n_obs = obs_q.size() - base_obs;
        checkOutput({tag, "_starts"}, 64'(n_obs), 64'(exp_q.size()));
        checkOutput({tag, "_start_gated"}, 64'(bad_start - base_bad), 64'd0);
        for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
            p = obs_q[base_obs + i];
            checkOutput($sformatf("%s_px%0d_sxy", tag, i), 64'({p.sx, p.sy}), 64'({exp_q[i].sx, exp_q[i].sy}));
            checkOutput($sformatf("%s_px%0d_fxy", tag, i), {p.fx, p.fy}, {exp_q[i].fx, exp_q[i].fy});
            checkOutput($sformatf("%s_px%0d_dxy", tag, i), 64'({p.dx, p.dy}), 64'({exp_q[i].dx, exp_q[i].dy}));
        end

        if (done_edges.size() > base_done) begin
            if (exp_q.size() == 0) begin
                // cfg_start driven after edge t0, done seen on edge t0+2.
                checkOutput({tag, "_empty_latency"}, 64'(done_edges[base_done] - t0), 64'd2);
            end else if (n_obs > 0) begin
                checkOutput({tag, "_drain_latency"},
                            64'(done_edges[base_done] - hs_edges[hs_edges.size() - 1]), 64'(DRAIN + 1));
            end
        end
        if (exp_q.size() > 0 && n_obs > 0 && mode == 0 && stall == 0) begin
            // cfg_start sampled on edge t0+1, first start accepted on edge t0+2.
            checkOutput({tag, "_first_start"}, 64'(hs_edges[base_hs] - t0), 64'd2);
        end
    endtask

    task automatic resetMidFrame();
        int base_hs, base_done;
        rdy_mode = 0;
        @(posedge clk); #1;
        cfg_src_w  = 18'd4;
        cfg_src_h  = 18'd4;
        cfg_dst_w  = 18'd4;
        cfg_dst_h  = 18'd4;
        cfg_step_x = 32'h4_0000;
        cfg_step_y = 32'h4_0000;
        cfg_start  = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_start", 64'(spg_in.start), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_sxy", 64'({spg_in.sx, spg_in.sy}), 64'd0);
        checkOutput("rst_mid_fxy", {spg_in.fx, spg_in.fy}, 64'd0);
        checkOutput("rst_mid_dxy", 64'({spg_in.dx, spg_in.dy}), 64'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        base_hs   = hs_edges.size();
        base_done = done_edges.size();
        repeat (30) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_mid_no_start", 64'(hs_edges.size() - base_hs), 64'd0);
        checkOutput("rst_mid_no_done", 64'(done_edges.size() - base_done), 64'd0);
        checkOutput("rst_mid_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        cfg_start  = 1'b0;
        cfg_src_w  = '0;
        cfg_src_h  = '0;
        cfg_dst_w  = '0;
        cfg_dst_h  = '0;
        cfg_step_x = '0;
        cfg_step_y = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_start", 64'(spg_in.start), 64'd0);
        checkOutput("reset_sxy", 64'({spg_in.sx, spg_in.sy}), 64'd0);
        checkOutput("reset_fxy", {spg_in.fx, spg_in.fy}, 64'd0);
        checkOutput("reset_dxy", 64'({spg_in.dx, spg_in.dy}), 64'd0);
        reset = 1'b0;

        applyStimulus("unit",    4, 4, 2, 2, 32'h4_0000, 32'h4_0000, 0, 0);
        applyStimulus("half",    4, 4, 3, 1, 32'h2_0000, 32'h4_0000, 0, 0);
        applyStimulus("clamp",   4, 4, 3, 1, 32'h8_0000, 32'h4_0000, 0, 0);
        applyStimulus("stall",   4, 4, 2, 2, 32'h4_0000, 32'h4_0000, 0, 20);
        applyStimulus("empty_w", 4, 4, 0, 3, 32'h4_0000, 32'h4_0000, 0, 0);
        applyStimulus("empty_h", 4, 4, 3, 0, 32'h4_0000, 32'h4_0000, 1, 0);
        resetMidFrame();

        for (int n = 0; n < 12; n++) begin
            logic [31:0] stx, sty;
            stx = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 32'h8_0000));
            sty = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 32'h8_0000));
            applyStimulus($sformatf("rnd%0d", n),
                          $urandom_range(2, 20), $urandom_range(2, 20),
                          $urandom_range(0, 6), $urandom_range(0, 4),
                          stx, sty, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
